// File: rtl/uart_rx_deframer_if.sv
// rtl/uart_rx_deframer_if.sv - serial line, tick and frame outputs of the UART receive deframer
interface uart_rx_deframer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  BaudTick;
    logic                  RxIn;
    logic [1:0]            ParityType;
    logic [DATA_WIDTH-1:0] RawData;
    logic                  ParityBit;
    logic                  Done;
    logic                  StopError;
    logic                  Busy;

    // master: the deframer itself; slave: line/tick driver and frame consumer
    modport master (
        input  BaudTick,
        input  RxIn,
        input  ParityType,
        output RawData,
        output ParityBit,
        output Done,
        output StopError,
        output Busy
    );

    modport slave (
        output BaudTick,
        output RxIn,
        output ParityType,
        input  RawData,
        input  ParityBit,
        input  Done,
        input  StopError,
        input  Busy
    );
endinterface

// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - UART receive deframer: 2-FF line sync, start detect, mid-bit sampling
module uart_rx_deframer #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    uart_rx_deframer_if.master    bus
);
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state, state_nx;
    logic                  sync1, rx_sync;
    logic [TW-1:0]         tick_cnt, tick_cnt_nx;
    logic [BW-1:0]         bit_cnt, bit_cnt_nx;
    logic [DATA_WIDTH-1:0] shift_reg, shift_nx;
    logic [DATA_WIDTH-1:0] raw_data, raw_data_nx;
    logic                  par_en, par_en_nx;
    logic                  parity_hold, parity_hold_nx;
    logic                  parity_bit, parity_bit_nx;
    logic                  stop_err, stop_err_nx;
    logic                  done, done_nx;

    // RxIn is asynchronous; both stages idle high so reset never looks like a start bit
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1   <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            sync1   <= bus.RxIn;
            rx_sync <= sync1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= S_IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            raw_data    <= '0;
            par_en      <= 1'b0;
            parity_hold <= 1'b0;
            parity_bit  <= 1'b0;
            stop_err    <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nx;
            tick_cnt    <= tick_cnt_nx;
            bit_cnt     <= bit_cnt_nx;
            shift_reg   <= shift_nx;
            raw_data    <= raw_data_nx;
            par_en      <= par_en_nx;
            parity_hold <= parity_hold_nx;
            parity_bit  <= parity_bit_nx;
            stop_err    <= stop_err_nx;
            done        <= done_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        tick_cnt_nx    = tick_cnt;
        bit_cnt_nx     = bit_cnt;
        shift_nx       = shift_reg;
        raw_data_nx    = raw_data;
        par_en_nx      = par_en;
        parity_hold_nx = parity_hold;
        parity_bit_nx  = parity_bit;
        stop_err_nx    = stop_err;
        done_nx        = 1'b0;

        // Everything but the synchroniser and the Done strobe is frozen between ticks
        if (bus.BaudTick) begin
            case (state)
                S_IDLE: begin
                    if (!rx_sync) begin
                        state_nx    = S_START;
                        tick_cnt_nx = '0;
                        par_en_nx   = (bus.ParityType == 2'b01) || (bus.ParityType == 2'b10);
                    end
                end
                S_START: begin
                    if (tick_cnt == TICK_HALF) begin
                        tick_cnt_nx = '0;
                        bit_cnt_nx  = '0;
                        state_nx    = rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        tick_cnt_nx = tick_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt_nx                = '0;
                        shift_nx                   = shift_reg >> 1;
                        shift_nx[DATA_WIDTH-1]     = rx_sync;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt_nx = '0;
                            state_nx   = par_en ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_nx = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_cnt_nx = tick_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt_nx    = '0;
                        parity_hold_nx = rx_sync;
                        state_nx       = S_STOP;
                    end else begin
                        tick_cnt_nx = tick_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt_nx   = '0;
                        raw_data_nx   = shift_reg;
                        parity_bit_nx = par_en ? parity_hold : 1'b1;
                        stop_err_nx   = ~rx_sync;
                        done_nx       = 1'b1;
                        state_nx      = S_IDLE;
                    end else begin
                        tick_cnt_nx = tick_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx    = S_IDLE;
                    tick_cnt_nx = '0;
                end
            endcase
        end
    end

    assign bus.RawData   = raw_data;
    assign bus.ParityBit = parity_bit;
    assign bus.StopError = stop_err;
    assign bus.Done      = done;
    assign bus.Busy      = (state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - directed bench for uart_rx_deframer
module tb_uart_rx_deframer;
    logic Clock;
    logic Reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   e_cyc = 0;
    int   tick_div = 1;
    int   tick_phase = 0;

    int   done_rises = 0, done_cycles = 0, last_done_cyc = -1;
    int   busy_rises = 0, busy_rise_cyc = -1, busy_fall_cyc = -1;
    bit   done_prev = 0, busy_prev = 0;
    int   d0, c0, b0;

    uart_rx_deframer_if #(.DATA_WIDTH(8)) bus ();

    uart_rx_deframer #(.DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    always @(negedge Clock) begin
        if (bus.Done) begin
            done_cycles++;
            if (!done_prev) begin
                done_rises++;
                last_done_cyc = cyc;
            end
        end
        done_prev = bus.Done;
        if (bus.Busy && !busy_prev) begin
            busy_rises++;
            busy_rise_cyc = cyc;
        end
        if (!bus.Busy && busy_prev) busy_fall_cyc = cyc;
        busy_prev = bus.Busy;
    end

    initial begin
        bus.BaudTick = 1'b1;
        forever begin
            @(negedge Clock);
            if (tick_div <= 1) begin
                bus.BaudTick = 1'b1;
            end else begin
                bus.BaudTick = (tick_phase == 0);
                tick_phase   = (tick_phase + 1) % tick_div;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic line_bit(input logic v, input int len);
        bus.RxIn = v;
        repeat (len) @(negedge Clock);
    endtask

    task automatic send_frame(input logic [7:0] data, input bit with_par, input bit par,
                              input bit stop, input int len);
        @(negedge Clock);
        e_cyc = cyc + 1;
        line_bit(1'b0, len);
        for (int i = 0; i < 8; i++) line_bit(data[i], len);
        if (with_par) line_bit(par, len);
        line_bit(stop, len);
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] data, input logic par,
                                 input logic serr);
        check({tag, "_raw"}, 32'(bus.RawData), 32'(data));
        check({tag, "_par"}, 32'(bus.ParityBit), 32'(par));
        check({tag, "_stoperr"}, 32'(bus.StopError), 32'(serr));
    endtask

    initial begin
        Reset          = 1'b1;
        bus.RxIn       = 1'b1;
        bus.ParityType = 2'b00;
        repeat (3) @(negedge Clock);
        check_outputs("reset", 8'h00, 1'b0, 1'b0);
        check("reset_done", 32'(bus.Done), 32'd0);
        check("reset_busy", 32'(bus.Busy), 32'd0);
        Reset = 1'b0;
        repeat (5) @(negedge Clock);

        // Odd parity 0x55
        bus.ParityType = 2'b01;
        d0 = done_rises; c0 = done_cycles;
        send_frame(8'h55, 1, 1'b1, 1'b1, 16);
        repeat (4) @(negedge Clock);
        check("odd_done_cnt", done_rises, d0 + 1);
        check("odd_done_width", done_cycles, c0 + 1);
        check("odd_done_time", last_done_cyc, e_cyc + 170);
        check("odd_busy_rise", busy_rise_cyc, e_cyc + 2);
        check("odd_busy_fall", busy_fall_cyc, e_cyc + 170);
        check_outputs("odd", 8'h55, 1'b1, 1'b0);

        // No parity 0xA3
        bus.ParityType = 2'b00;
        d0 = done_rises;
        send_frame(8'hA3, 0, 1'b0, 1'b1, 16);
        repeat (4) @(negedge Clock);
        check("nopar_done_cnt", done_rises, d0 + 1);
        check("nopar_done_time", last_done_cyc, e_cyc + 154);
        check_outputs("nopar", 8'hA3, 1'b1, 1'b0);

        // Glitch: 4 low cycles enter START but the start sample rejects it
        d0 = done_rises; b0 = busy_rises;
        line_bit(1'b0, 4);
        line_bit(1'b1, 40);
        check("glitch_done_cnt", done_rises, d0);
        check("glitch_busy_seen", busy_rises, b0 + 1);
        check("glitch_busy_end", 32'(bus.Busy), 32'd0);
        check_outputs("glitch", 8'hA3, 1'b1, 1'b0);

        // Frame error: even parity 0x0F, stop bit 0, line left low
        bus.ParityType = 2'b10;
        d0 = done_rises;
        send_frame(8'h0F, 1, 1'b0, 1'b0, 16);
        check("ferr_done_cnt", done_rises, d0 + 1);
        check("ferr_done_time", last_done_cyc, e_cyc + 170);
        check_outputs("ferr", 8'h0F, 1'b0, 1'b1);
        check("ferr_restart_busy", 32'(bus.Busy), 32'd1);
        line_bit(1'b1, 30);
        check("ferr_restart_abort", 32'(bus.Busy), 32'd0);
        check("ferr_no_extra_done", done_rises, d0 + 1);

        // Reset during data bit 4 of 0x3C
        bus.ParityType = 2'b00;
        d0 = done_rises;
        line_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) line_bit(((8'h3C >> i) & 8'h01) != 0, 16);
        line_bit(1'b1, 8);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        check_outputs("midrst", 8'h00, 1'b0, 1'b0);
        check("midrst_done", 32'(bus.Done), 32'd0);
        check("midrst_busy", 32'(bus.Busy), 32'd0);
        line_bit(1'b1, 40);
        check("midrst_no_done", done_rises, d0);
        send_frame(8'h3C, 0, 1'b0, 1'b1, 16);
        repeat (4) @(negedge Clock);
        check("after_rst_done_cnt", done_rises, d0 + 1);
        check("after_rst_done_time", last_done_cyc, e_cyc + 154);
        check_outputs("after_rst", 8'h3C, 1'b1, 1'b0);

        // Slow tick: BaudTick every 4th cycle, odd parity 0xC6
        tick_div = 4;
        bus.ParityType = 2'b01;
        repeat (8) @(negedge Clock);
        d0 = done_rises; c0 = done_cycles;
        send_frame(8'hC6, 1, 1'b1, 1'b1, 64);
        repeat (8) @(negedge Clock);
        check("slow_done_cnt", done_rises, d0 + 1);
        check("slow_done_width", done_cycles, c0 + 1);
        check_outputs("slow", 8'hC6, 1'b1, 1'b0);
        check("slow_busy_end", 32'(bus.Busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

- UART receive front end; sits directly upstream of the receive parity error-check stage.
- Synchronises the serial line, detects the start bit and samples each bit at mid-point using an oversampling tick.
- Assembles the data bits LSB first, captures the optional parity bit and checks the stop bit.
- Presents `RawData` and `ParityBit`, with a one-cycle `Done` strobe, for the error-check stage to consume.

## Interface
- `DATA_WIDTH`, default 8: number of data bits per frame.
- `OVERSAMPLE`, default 16: `BaudTick` pulses per bit period.
- `Clock` — input, 1: system clock; all logic on the rising edge.
- `Reset` — input, 1: synchronous, active-high reset.
- `BaudTick` — input, 1: one-cycle enable at OVERSAMPLE × baud rate.
- `RxIn` — input, 1: asynchronous serial line; idles high.
- `ParityType` — input, 2: 01 odd, 10 even, 00/11 no parity. Same encoding as the error-check stage.
- `RawData` — output, DATA_WIDTH: last received data word.
- `ParityBit` — output, 1: received parity bit. Forced to 1 for no-parity frames.
- `Done` — output, 1: one-cycle strobe; a new frame is valid on the outputs.
- `StopError` — output, 1: stop bit of the last frame was sampled 0.
- `Busy` — output, 1: high in every state except IDLE.

## Operation
- **Input sync**
  - `RxIn` passes through a 2-FF synchroniser before any use.
  - Both stages reset to 1. `RxSync` is the stage-2 output.
- **Counters**
  - Tick counter: 0..OVERSAMPLE-1. It advances only on cycles with `BaudTick`=1.
  - Bit counter: 0..DATA_WIDTH-1.
- **ParityType latch:** `ParityType` is latched on the IDLE→START transition; mid-frame changes are ignored. P = 1 if the latched type is 01/10, else 0.
- **FSM states**
  - **IDLE**
    - When `RxSync`=0: go to START and clear the tick counter.
  - **START**
    - On a tick with count = OVERSAMPLE/2-1 (7 at default), sample `RxSync`.
    - Sample 0: go to DATA and clear the counter.
    - Sample 1: glitch; return to IDLE with no outputs changed.
  - **DATA**
    - On a tick with count = OVERSAMPLE-1: shift `RxSync` into the shift-register MSB (right shift, so the first bit ends up in LSB) and clear the counter.
    - After DATA_WIDTH bits: go to PARITY if P=1, else go to STOP.
  - **PARITY**
    - On a tick with count = OVERSAMPLE-1: capture `RxSync` into the parity holding register, go to STOP, clear the counter.
  - **STOP**
    - On a tick with count = OVERSAMPLE-1, in a single edge:
      - `RawData` ← shift register.
      - `ParityBit` ← captured parity bit if P=1, else 1.
      - `StopError` ← ~`RxSync`.
      - `Done` ← 1.
      - State ← IDLE.
- **Output holding:** `RawData`, `ParityBit` and `StopError` change only at the STOP sample edge and hold until the next frame completes.
- **Break / frame error:** no special handling. If the line is still low after a frame error, IDLE immediately starts a new frame.

## Timing
- **Reset values (after `Reset` high at an edge)**
  - State IDLE; both counters 0.
  - `RawData`=0, `ParityBit`=0, `StopError`=0, `Done`=0, `Busy`=0.
  - Synchroniser = 1.
  - Reset mid-frame aborts the frame with no `Done`.
- **Reference edge E:** the first edge at which synchroniser stage 1 captures `RxIn`=0. Cycle counts below assume `BaudTick` held high.
  - E+2: IDLE→START.
  - E+10: start-bit sample.
  - Data bit k: sampled at E+10+16(k+1).
  - Stop bit: sampled at E+10+16(DATA_WIDTH+P+1).
  - `Done` is high during the cycle following the stop-sample edge: E+170 with parity, E+154 without (defaults).
- **Done:** exactly one cycle wide; never asserted back-to-back.
- **Busy:** rises the cycle after the IDLE→START edge; falls together with the `Done` rise.
- **BaudTick low:** the FSM holds state and counters; only the synchroniser runs.
- **Reset priority:** `Reset` overrides `BaudTick` and all transitions in the same cycle.

## Test plan
- **Odd parity, 0x55**
  - Stimulus: `ParityType`=01, `BaudTick`=1, 16-cycle bits: start, bits 1,0,1,0,1,0,1,0 (0x55 LSB first), parity 1, stop 1.
  - Response: `Done` pulse at E+170, `RawData`=0x55, `ParityBit`=1, `StopError`=0.
- **No parity, 0xA3**
  - Stimulus: `ParityType`=00, frame 0xA3, stop 1.
  - Response: `Done` at E+154, `RawData`=0xA3, `ParityBit`=1.
- **Glitch rejection**
  - Stimulus: `RxIn` low for 4 cycles, then high.
  - Response: FSM returns to IDLE, `Done` never asserts, outputs unchanged.
- **Frame error**
  - Stimulus: even parity, 0x0F, parity 0, stop bit 0.
  - Response: `Done` pulse, `RawData`=0x0F, `ParityBit`=0, `StopError`=1. Holding `RxIn` low afterwards starts a new frame.
- **Reset mid-frame**
  - Stimulus: assert `Reset` for 1 cycle during bit 4 of a frame.
  - Response: all outputs 0, state IDLE, no `Done`; the next full frame 0x3C is received correctly.
- **Slow tick**
  - Stimulus: `BaudTick` every 4th cycle, frame 0xC6, odd parity (parity 1).
  - Response: `RawData`=0xC6, `ParityBit`=1, `Done` a single cycle wide.
